// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings, state enum, byte-enable constants and counter sizing for mem_access_unit
package mau_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: store lane replication / byte enables and load lane extract with sign or zero extension
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);
  logic is_byte, is_half;
  logic [4:0] amt;
  logic [31:0] sh;
  assign is_byte = size == SZ_BYTE;
  assign is_half = size == SZ_HALF;
  // halves ignore lo[0] and words ignore lo entirely, so unaligned forms fold onto legal lanes
  assign amt = is_byte ? {lo, 3'b000} : is_half ? {lo[1], 4'b0000} : 5'd0;
  assign be = is_byte ? BE_BYTE << lo : is_half ? BE_HALF << {lo[1], 1'b0} : BE_WORD;
  assign wrep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
  assign sh = rdata >> amt;
  assign rext = is_byte ? {{24{sgn & sh[7]}}, sh[7:0]} :
                is_half ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator to word memory; optional MISALIGN_TRAP_EN traps misaligned half/word
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              bus_err,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  state_e state;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] lat_size, lat_lo;
  logic lat_sgn, lat_we, idle, trap;
  logic [3:0] be;
  logic [31:0] wrep, rext;
  assign idle = state == ST_IDLE;
  assign cnt_n = cnt + CW'(1);
`ifdef MISALIGN_TRAP_EN
  assign trap = (cpu_size == SZ_HALF && cpu_addr[0]) || (cpu_size[1] && cpu_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  // live request drives lane logic while idle; the latched request is used for load extraction
  mau_lane_align u_align (
    .size  (idle ? cpu_size : lat_size),
    .lo    (idle ? cpu_addr[1:0] : lat_lo),
    .sgn   (lat_sgn),
    .wdata (cpu_wdata),
    .rdata (mem_rdata),
    .be    (be),
    .wrep  (wrep),
    .rext  (rext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_size     <= '0;
      lat_lo       <= '0;
      lat_sgn      <= 1'b0;
      lat_we       <= 1'b0;
      cpu_busy     <= 1'b0;
      cpu_done     <= 1'b0;
      cpu_rdata    <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      mem_req      <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cpu_req) begin
          lat_size     <= cpu_size;
          lat_lo       <= cpu_addr[1:0];
          lat_sgn      <= cpu_signed;
          lat_we       <= cpu_we;
          cnt          <= '0;
          cpu_busy     <= 1'b1;
          state        <= trap ? ST_RESP : ST_BUS;
          cpu_done     <= trap;
          misalign_err <= trap;
          mem_req      <= !trap;
          mem_rw       <= cpu_we;
          mem_addr     <= {cpu_addr[ADDR_W-1:2], 2'b00};
          mem_be       <= be;
          mem_wdata    <= wrep;
        end
        ST_BUS: begin
          cnt <= cnt_n;
          // ready wins over a timeout landing on the same cycle
          if (mem_ready || cnt_n == CNT_MAX) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            cpu_done  <= 1'b1;
            bus_err   <= !mem_ready;
            cpu_rdata <= (mem_ready && !lat_we) ? rext : '0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          cpu_busy     <= 1'b0;
          cpu_done     <= 1'b0;
          bus_err      <= 1'b0;
          misalign_err <= 1'b0;
          cpu_rdata    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store bench against a byte-lane reference model
module tb_mem_access_unit;
  localparam int T = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 0, cpu_we = 0, cpu_signed = 0, mem_ready = 0;
  logic [1:0] cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
  logic cpu_busy, cpu_done, bus_err, misalign_err, mem_req, mem_rw;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_chk = 0, n_pass = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .bus_err(bus_err), .misalign_err(misalign_err),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return off >= 2 ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] rd);
    int off = int'(a % 4);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (rd >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
      if (sg && v >= 32768) v = v - 65536;
    end else v = rd;
    return v;
  endfunction

  function automatic bit m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // d = BUS cycle on which mem_ready is raised; d > T means never
  task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int d);
    bit trap = m_trap(sz, a);
    int k = 0, reqs = 0, lat;
    cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_signed = sg; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_we = 1'($urandom); cpu_size = 2'($urandom); cpu_signed = 1'($urandom);
    cpu_addr = $urandom; cpu_wdata = $urandom;
    chk("busy", cpu_busy, 1);
    if (trap) chk("no_req", mem_req, 0);
    else begin
      chk("req", mem_req, 1);
      chk("rw", mem_rw, we);
      chk("addr", mem_addr, a & ~32'h3);
      chk("be", mem_be, m_be(sz, a));
      chk("wdata", mem_wdata, m_wdata(sz, wd));
    end
    mem_rdata = rd;
    while (!cpu_done && k < 40) begin
      if (mem_req) reqs++;
      mem_ready = (k + 1 == d);
      @(posedge clk); #1;
      k++;
    end
    lat = trap ? 0 : (d < T ? d : T);
    chk("latency", k, lat);
    chk("req_cycles", reqs, lat);
    chk("bus_err", bus_err, !trap && d > T);
    chk("misalign", misalign_err, trap);
    chk("rdata", cpu_rdata, (trap || we || d > T) ? 32'h0 : m_load(sz, sg, a, rd));
    chk("req_low", mem_req, 0);
    mem_ready = 1'($urandom);
    cpu_req = 0;
    @(posedge clk); #1;
    chk("done_pulse", cpu_done, 0);
    chk("idle", cpu_busy, 0);
    mem_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1;
    @(posedge clk); #1;
    access(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
    access(0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF1234, 1);
    access(0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF1234, 3);
    access(1, 2'd1, 0, 32'h06, 32'hA5A51234, 32'h0, 2);
    access(0, 2'd1, 1, 32'h06, 32'h0, 32'h12341234, 1);
    access(0, 2'd2, 0, 32'h20, 32'h0, 32'h55AA55AA, 100);
    access(0, 2'd2, 0, 32'h24, 32'h0, 32'hCAFEF00D, T);
    access(0, 2'd2, 0, 32'h12, 32'h0, 32'h11223344, 1);
    access(0, 2'd3, 1, 32'h31, 32'h0, 32'h89ABCDEF, 2);
    access(0, 2'd1, 1, 32'h45, 32'h0, 32'hF00F8001, 1);
    // reset while a read is outstanding
    cpu_req = 1; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h40;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #3;
    mem_ready = 1;
    rst_n = 0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_busy", cpu_busy, 0);
    chk("arst_done", cpu_done, 0);
    cpu_req = 0;
    @(posedge clk); #2;
    rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_done", cpu_done, 0);
      chk("post_rst_req", mem_req, 0);
    end
    mem_ready = 0;
    access(0, 2'd2, 0, 32'h40, 32'h0, 32'h0BADF00D, 2);
    for (int i = 0; i < 60; i++)
      access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 4) == 0 ? $urandom_range(T, T + 3) : $urandom_range(1, 5));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
